myram_port_arbiter: RTL
=======================

// Module: myram_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port 512x32 myRAM block (byte-enabled, one access/clock).
//  Clears the whole RAM after reset, then shares the port round-robin between requester A and requester B.
//  Returns read data to the issuing requester after the fixed RAM read latency.
//  Sits directly in front of myRAM; drives all of its inputs.
// PARAMETERS
//  ADDR_W      9   RAM address width; DEPTH = 2**ADDR_W words
//  DATA_W      32  RAM word width; byte-enable width = DATA_W/8
//  RD_LATENCY  2   clocks from the read-issue edge to valid ram_q (>=1)
//  INIT_CLEAR  1   1 = zero every word after reset; 0 = skip the clear
// PORTS
//  clock        in   1       single clock for block and RAM
//  reset_n      in   1       asynchronous, active-low reset
//  init_done    out  1       high once the clear has finished (RUN state)
//  a_req        in   1       A access request; held with its fields until a_gnt
//  a_wr         in   1       1 = write, 0 = read
//  a_addr       in   ADDR_W  A word address
//  a_wdata      in   DATA_W  A write data
//  a_be         in   DATA_W/8  A byte enables (writes only)
//  a_gnt        out  1       A access issued this cycle
//  a_rvalid     out  1       A read data valid
//  a_rdata      out  DATA_W  A read data (0 when a_rvalid=0)
//  b_*          same set as a_* for requester B
//  ram_address  out  ADDR_W  to myRAM.address
//  ram_data     out  DATA_W  to myRAM.data
//  ram_wren     out  1       to myRAM.wren
//  ram_byteena  out  DATA_W/8  to myRAM.byteena
//  ram_q        in   DATA_W  from myRAM.q
// BEHAVIOUR
//  Reset (async, reset_n=0): state=INIT, clear counter=0, rr pointer=B (A wins the first tie), read pipe flushed.
//   Reset outputs: gnt/rvalid/init_done/ram_wren=0; rdata/ram_address/ram_data/ram_byteena=0.
//  FSM INIT (INIT_CLEAR=1): one clear write per cycle, 0..DEPTH-1: ram_wren=1, ram_byteena=all-1, ram_data=0.
//   Clear takes DEPTH cycles. Go to RUN on the cycle after address DEPTH-1 is written.
//   During INIT: a_gnt=b_gnt=0 and requests are ignored (not lost: req stays held).
//  INIT_CLEAR=0: go to RUN on the first clock after reset release; INIT issues no RAM writes.
//  RUN: init_done=1. The arbiter is combinational on req; the RAM registers its own inputs.
//   Only one req: that requester is granted the same cycle. No bubbles, back-to-back every cycle.
//   Both req: grant the requester not granted most recently; the rr pointer updates on every grant.
//   Neither req: ram_wren=0; ram_address/data/byteena hold their last value.
//   On grant: ram_address=addr, ram_wren=wr, ram_data=wdata; ram_byteena=be for a write, all-1 for a read.
//   Reads carry a 1-bit tag down a RD_LATENCY-deep shift pipe.
//    Tag emerges RD_LATENCY cycles after the grant cycle, asserting x_rvalid for 1 cycle.
//    In that cycle x_rdata=ram_q. Writes produce no rvalid.
//   Reads return in issue order. Up to RD_LATENCY reads may be in flight.
//   a_rvalid and b_rvalid are never high together.
//   Read after write to the same address in the next cycle returns the new data (RAM ordering, no bypass here).
//  Reset mid-operation: in-flight reads are discarded (no rvalid after release); FSM restarts INIT and the clear.
//  Address wrap: the clear counter is ADDR_W+1 bits so terminal count DEPTH-1 is exact; no RUN-state wrap logic.
// TESTING
//  1 Release reset, INIT_CLEAR=1: 512 writes addr 0..511, data 0, be F; init_done rises 1 clk after addr 511; no gnt before.
//  2 A write 0x12345678 @0x010 be=F, then A read @0x010: a_gnt each cycle; a_rvalid exactly 2 clk after read grant, a_rdata=0x12345678.
//  3 Cleared RAM, B write 0xAABBCCDD @0x1FF be=4'b0101, then read @0x1FF -> b_rdata=0x00BB00DD.
//  4 A and B reading continuously: grants A,B,A,B...; every rvalid on the correct port, in order, data from its own address.
//  5 Only B requesting, A idle: b_gnt high every cycle; 8 back-to-back reads give 8 consecutive b_rvalid.
//  6 reset_n low with 2 reads in flight: gnt/rvalid drop immediately; no rvalid after release; clear restarts at addr 0.

Source files
------------

// File: rtl/myram_port_arbiter_if.sv
// Requester-side handshake bundle for the myRAM port arbiter: one instance per requester.
// The requester holds req and its fields until gnt; read data comes back on rvalid/rdata.

interface myram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/myram_port_arbiter.sv
// Round-robin arbiter/sequencer for the single-port myRAM: zeroes the RAM after reset,
// then shares the port between requesters A and B and routes read data back by tag.
//
// state   | meaning
// ST_INIT | post-reset clear, one word per clock (single pass-through cycle if clearing is off)
// ST_RUN  | combinational round-robin grant, one RAM access per clock

module myram_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  init_done,
    myram_port_arbiter_if.slave   a_port,
    myram_port_arbiter_if.slave   b_port,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W-1:0]     ram_data,
    output logic                  ram_wren,
    output logic [DATA_W/8-1:0]   ram_byteena,
    input  logic [DATA_W-1:0]     ram_q
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       clr_cnt_q, clr_cnt_d;
    logic                  rr_b_q, rr_b_d;

    logic [ADDR_W-1:0]     hold_addr_q;
    logic [DATA_W-1:0]     hold_data_q;
    logic [BE_W-1:0]       hold_be_q;

    logic [RD_LATENCY-1:0] pipe_v_q;
    logic [RD_LATENCY-1:0] pipe_b_q;

    logic                  a_req, a_wr, b_req, b_wr;
    logic [ADDR_W-1:0]     a_addr, b_addr;
    logic [DATA_W-1:0]     a_wdata, b_wdata;
    logic [BE_W-1:0]       a_be, b_be;
    logic                  a_gnt, b_gnt;
    logic                  a_rvalid, b_rvalid;

    logic                  drv_en;
    logic                  drv_wren;
    logic [ADDR_W-1:0]     drv_addr;
    logic [DATA_W-1:0]     drv_data;
    logic [BE_W-1:0]       drv_be;
    logic                  rd_issue;

    assign a_req   = a_port.req;
    assign a_wr    = a_port.wr;
    assign a_addr  = a_port.addr;
    assign a_wdata = a_port.wdata;
    assign a_be    = a_port.be;
    assign b_req   = b_port.req;
    assign b_wr    = b_port.wr;
    assign b_addr  = b_port.addr;
    assign b_wdata = b_port.wdata;
    assign b_be    = b_port.be;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            rr_b_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_b_q    <= rr_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_b_d    = rr_b_q;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        drv_en    = 1'b0;
        drv_wren  = 1'b0;
        drv_addr  = hold_addr_q;
        drv_data  = hold_data_q;
        drv_be    = hold_be_q;

        case (state_q)
            ST_INIT: begin
                if (INIT_CLEAR != 0) begin
                    drv_en    = 1'b1;
                    drv_wren  = 1'b1;
                    drv_addr  = clr_cnt_q[ADDR_W-1:0];
                    drv_data  = '0;
                    drv_be    = '1;
                    clr_cnt_d = clr_cnt_q + CLR_ONE;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // rr_b_q set means B was granted last, so A wins a tie
                a_gnt = a_req & (~b_req | rr_b_q);
                b_gnt = b_req & (~a_req | ~rr_b_q);
                if (a_gnt) begin
                    drv_en   = 1'b1;
                    drv_wren = a_wr;
                    drv_addr = a_addr;
                    drv_data = a_wdata;
                    drv_be   = a_wr ? a_be : '1;
                    rr_b_d   = 1'b0;
                end else if (b_gnt) begin
                    drv_en   = 1'b1;
                    drv_wren = b_wr;
                    drv_addr = b_addr;
                    drv_data = b_wdata;
                    drv_be   = b_wr ? b_be : '1;
                    rr_b_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Idle cycles keep the RAM inputs at whatever was last driven.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_be_q   <= '0;
        end else if (drv_en) begin
            hold_addr_q <= drv_addr;
            hold_data_q <= drv_data;
            hold_be_q   <= drv_be;
        end
    end

    assign rd_issue = (a_gnt & ~a_wr) | (b_gnt & ~b_wr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v_q <= '0;
            pipe_b_q <= '0;
        end else begin
            pipe_v_q[0] <= rd_issue;
            pipe_b_q[0] <= b_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_b_q[i] <= pipe_b_q[i-1];
            end
        end
    end

    assign a_rvalid = pipe_v_q[RD_LATENCY-1] & ~pipe_b_q[RD_LATENCY-1];
    assign b_rvalid = pipe_v_q[RD_LATENCY-1] &  pipe_b_q[RD_LATENCY-1];

    assign a_port.gnt    = a_gnt;
    assign b_port.gnt    = b_gnt;
    assign a_port.rvalid = a_rvalid;
    assign b_port.rvalid = b_rvalid;
    assign a_port.rdata  = a_rvalid ? ram_q : '0;
    assign b_port.rdata  = b_rvalid ? ram_q : '0;

    assign init_done = (state_q == ST_RUN);

    // The clear write is driven combinationally from ST_INIT, so it is masked while reset is held.
    assign ram_wren    = drv_wren & reset_n;
    assign ram_address = reset_n ? drv_addr : '0;
    assign ram_data    = reset_n ? drv_data : '0;
    assign ram_byteena = reset_n ? drv_be   : '0;

endmodule
